ls_seq_ctrl: RTL
================

Name: ls_seq_ctrl

Overview:
Sequencer for the load/store datapath: register bank, sign-extended offset adder and single-port word-addressed block RAM. It accepts one load or store command per start pulse and reads the base and data registers. It computes the word address as base + sext(imm), runs the BRAM access (accounting for read latency) and writes load data back to the register bank. It replaces ad-hoc per-button sequencing and signals completion with done/err.

Parameters:
ADDR_W, 10, BRAM word-address width; valid word addresses are 0 .. 2**ADDR_W-1.
READ_LATENCY, 1, BRAM read latency in clocks (legal values 1 or 2).
IMM_W, 6, immediate offset width; two's complement.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  command request; sampled only in IDLE
ls_op  in  1  0 = load, 1 = store
rd_rs  in  4  load destination / store source register
base_reg  in  4  address base register
imm  in  IMM_W  signed word offset
rf_raddr_a  out  4  register bank read port A (base)
rf_raddr_b  out  4  register bank read port B (store data)
rf_rdata_a  in  32  base value
rf_rdata_b  in  32  store data
rf_we  out  1  register bank write strobe
rf_waddr  out  4  writeback register
rf_wdata  out  32  writeback data
mem_en  out  1  BRAM enable
mem_we  out  4  BRAM byte write enables
mem_addr  out  ADDR_W  BRAM word address
mem_din  out  32  BRAM write data
mem_dout  in  32  BRAM read data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  address fault; valid while done is high

Behaviour:
- All outputs registered. Reset values: every output is 0, and state = IDLE.
- States: IDLE, DECODE, ADDR, MEM, WAIT, WB, DONE.
- IDLE, start = 1 at edge E0: latch ls_op, rd_rs, base_reg, imm; go to DECODE.
  - Numbering: cycle n is the cycle after edge E(n-1).
- DECODE (cycle 1): rf_raddr_a = base_reg, rf_raddr_b = rd_rs.
- ADDR (cycle 2):
  - Compute a32 = rf_rdata_a + sext32(imm); latch rf_rdata_b as store data.
  - Fault when a32[31] = 1 or a32 >= 2**ADDR_W. On fault go to DONE with err = 1; mem_en is never asserted.
- MEM (cycle 3):
  - mem_en = 1, mem_addr = a32[ADDR_W-1:0].
  - Store: mem_we = 4'b1111 and mem_din = latched data; next state DONE.
  - Load: mem_we = 0; next state WAIT.
- WAIT (load only, READ_LATENCY cycles, counter-driven): mem_en held at 1. mem_dout is captured into the read-data register on the final WAIT edge.
- WB (one cycle): rf_we = 1, rf_waddr = rd_rs, rf_wdata = captured data.
- DONE (one cycle): done = 1 and err as computed; return to IDLE.
- Latency from the accepting edge:
  - store: done in cycle 4
  - load: done in cycle 5 + READ_LATENCY
  - fault: done in cycle 3
- mem_we is nonzero for exactly one cycle per store. rf_we is high for exactly one cycle per load and never on a store or fault.
- start while busy is ignored; it is not queued. start held high re-launches on the cycle after DONE.
- Command inputs are sampled only at acceptance; later changes have no effect.
- rst mid-operation: the next edge forces IDLE and clears all outputs. A write already committed by the BRAM is not undone. No rf_we and no done are emitted for the aborted command.
- Offsets are word offsets; the byte-address-to-word conversion is the caller's concern.

Decomposition:
- Package ls_ctrl_pkg:
  - state enum/localparams
  - LS_LOAD = 0, LS_STORE = 1
  - WE_ALL = 4'b1111, WE_NONE = 4'b0000
- One combinational sub-module, ls_addr_gen: sign-extend, add and range check. Inputs base, imm; outputs addr, fault. Parameterised by ADDR_W and IMM_W.

Test Plan:
- R2 = 8, R3 = 0xDEADBEEF; store rd_rs = 3, base_reg = 2, imm = +4 -> mem_addr = 12, mem_we = 1111 only in cycle 3, mem_din = 0xDEADBEEF, done in cycle 4, err = 0, rf_we never high.
- Then load rd_rs = 5, base_reg = 2, imm = +4 (READ_LATENCY = 1) -> mem_en in cycles 3-4, rf_we in cycle 5 with waddr = 5 and wdata = 0xDEADBEEF, done in cycle 6.
- R2 = 8: imm = -8 -> addr 0, no err. imm = -9 -> err = 1 with done in cycle 3, mem_en never high. R2 = 1020, imm = +4, ADDR_W = 10 -> err = 1.
- start pulsed in cycles 2 and 3 of an active load -> exactly one done, and busy returns to 0 after DONE.
- rst asserted in the WAIT cycle of a load -> all outputs 0 on the next cycle, no rf_we, no done. A following store completes normally.
- READ_LATENCY = 2 rerun of the load scenario -> rf_we in cycle 6, done in cycle 7, correct data.

Source files
------------

// File: rtl/ls_ctrl_pkg.sv
// Shared types and constants for the load/store sequencer slice.
// Imported by the sequencer top and the address generator.
package ls_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_ADDR   = 3'd2,
    S_MEM    = 3'd3,
    S_WAIT   = 3'd4,
    S_WB     = 3'd5,
    S_DONE   = 3'd6
  } ls_state_e;

  localparam logic       LS_LOAD  = 1'b0;
  localparam logic       LS_STORE = 1'b1;
  localparam logic [3:0] WE_ALL   = 4'b1111;
  localparam logic [3:0] WE_NONE  = 4'b0000;

endpackage

// File: rtl/ls_addr_gen.sv
// Word-address generator: base + sign-extended immediate, with a range check
// that rejects negative results and anything past the last BRAM word.
module ls_addr_gen #(
  parameter int ADDR_W = 10,
  parameter int IMM_W  = 6
) (
  input  logic [31:0]       i_base,
  input  logic [IMM_W-1:0]  i_imm,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_fault
);

  logic [31:0] w_imm_sext;
  logic [31:0] w_a32;

  assign w_imm_sext = {{(32-IMM_W){i_imm[IMM_W-1]}}, i_imm};
  assign w_a32      = i_base + w_imm_sext;

  // Bit 31 set (negative) or any bit above the address field means out of range.
  assign o_addr  = w_a32[ADDR_W-1:0];
  assign o_fault = |w_a32[31:ADDR_W];

endmodule

// File: rtl/ls_seq_ctrl.sv
// Load/store sequencer: one command per start pulse, reads base/data from the
// register bank, runs the BRAM access and writes load data back.
module ls_seq_ctrl
  import ls_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int READ_LATENCY = 1,
  parameter int IMM_W        = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_ls_op,
  input  logic [3:0]        i_rd_rs,
  input  logic [3:0]        i_base_reg,
  input  logic [IMM_W-1:0]  i_imm,
  output logic [3:0]        o_rf_raddr_a,
  output logic [3:0]        o_rf_raddr_b,
  input  logic [31:0]       i_rf_rdata_a,
  input  logic [31:0]       i_rf_rdata_b,
  output logic              o_rf_we,
  output logic [3:0]        o_rf_waddr,
  output logic [31:0]       o_rf_wdata,
  output logic              o_mem_en,
  output logic [3:0]        o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_din,
  input  logic [31:0]       i_mem_dout,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output ls_state_e         o_state
);

  // Handshake: i_start is a request honoured only in IDLE (no ready signal);
  // o_done is a one-cycle completion pulse and o_err is meaningful only with it.

  localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

  ls_state_e         r_state;
  logic              r_op;
  logic [3:0]        r_rd;
  logic [IMM_W-1:0]  r_imm;
  logic [1:0]        r_wait_cnt;

  logic [3:0]        r_rf_raddr_a;
  logic [3:0]        r_rf_raddr_b;
  logic              r_rf_we;
  logic [3:0]        r_rf_waddr;
  logic [31:0]       r_rf_wdata;
  logic              r_mem_en;
  logic [3:0]        r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_din;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [ADDR_W-1:0] w_addr;
  logic              w_fault;

  ls_addr_gen #(
    .ADDR_W (ADDR_W),
    .IMM_W  (IMM_W)
  ) u_addr_gen (
    .i_base  (i_rf_rdata_a),
    .i_imm   (r_imm),
    .o_addr  (w_addr),
    .o_fault (w_fault)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= LS_LOAD;
      r_rd         <= 4'd0;
      r_imm        <= '0;
      r_wait_cnt   <= 2'd0;
      r_rf_raddr_a <= 4'd0;
      r_rf_raddr_b <= 4'd0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= 4'd0;
      r_rf_wdata   <= 32'd0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= WE_NONE;
      r_mem_addr   <= '0;
      r_mem_din    <= 32'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_op         <= i_ls_op;
            r_rd         <= i_rd_rs;
            r_imm        <= i_imm;
            r_rf_raddr_a <= i_base_reg;
            r_rf_raddr_b <= i_rd_rs;
            r_busy       <= 1'b1;
            r_state      <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_state <= S_ADDR;
        end
        S_ADDR: begin
          // A faulting address skips the BRAM entirely.
          if (w_fault) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_mem_en   <= 1'b1;
            r_mem_addr <= w_addr;
            if (r_op == LS_STORE) begin
              r_mem_we  <= WE_ALL;
              r_mem_din <= i_rf_rdata_b;
            end
            r_state <= S_MEM;
          end
        end
        S_MEM: begin
          if (r_op == LS_STORE) begin
            r_mem_en  <= 1'b0;
            r_mem_we  <= WE_NONE;
            r_mem_din <= 32'd0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_wait_cnt <= WAIT_INIT;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Enable stays high so a pipelined BRAM keeps advancing its output.
          if (r_wait_cnt == 2'd0) begin
            r_mem_en   <= 1'b0;
            r_rf_we    <= 1'b1;
            r_rf_waddr <= r_rd;
            r_rf_wdata <= i_mem_dout;
            r_state    <= S_WB;
          end else begin
            r_wait_cnt <= r_wait_cnt - 2'd1;
          end
        end
        S_WB: begin
          r_rf_we <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_rf_raddr_a = r_rf_raddr_a;
  assign o_rf_raddr_b = r_rf_raddr_b;
  assign o_rf_we      = r_rf_we;
  assign o_rf_waddr   = r_rf_waddr;
  assign o_rf_wdata   = r_rf_wdata;
  assign o_mem_en     = r_mem_en;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_din    = r_mem_din;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_state      = r_state;

endmodule
